// File: rtl/tc_tile_loader_pkg.sv
// Shared tile-loader/core definitions: default geometry,
// loader FSM states and operand selector.
package tc_tile_loader_pkg;

  localparam int TC_M       = 16;
  localparam int TC_DW_DATA = 16;
  localparam int TC_DW_IDX  = 4;
  localparam int TC_DW_MEM  = 256;
  localparam int TC_DW_ADDR = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_C,
    DRAIN,
    COMPUTE,
    WAIT_OUT,
    DONE
  } tl_state_e;

  typedef enum logic [1:0] {
    OP_A,
    OP_B,
    OP_C
  } tl_op_e;

endpackage

// File: rtl/tc_tile_loader_if.sv
// Row-read memory port: request/grant with
// data returned one cycle after the grant.
interface tc_tile_loader_if #(
  parameter int DW_ADDR = 16,
  parameter int DW_MEM  = 256
);

  logic               mem_rd_en;
  logic [DW_ADDR-1:0] mem_rd_addr;
  logic               mem_gnt;
  logic [DW_MEM-1:0]  mem_rd_data;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_gnt,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_gnt,
    output mem_rd_data
  );

endinterface

// File: rtl/tc_row_addr_gen.sv
// Latches the three operand bases and walks the
// row counter; forms base + row for the selected operand.
module tc_row_addr_gen
  import tc_tile_loader_pkg::*;
#(
  parameter int M       = TC_M,
  parameter int DW_IDX  = TC_DW_IDX,
  parameter int DW_ADDR = TC_DW_ADDR
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               latch,
  input  logic [DW_ADDR-1:0] a_base,
  input  logic [DW_ADDR-1:0] b_base,
  input  logic [DW_ADDR-1:0] c_base,
  input  tl_op_e             sel,
  input  logic               adv,
  output logic [DW_IDX-1:0]  row,
  output logic [DW_ADDR-1:0] addr,
  output logic               last
);

  logic [DW_ADDR-1:0] a_q;
  logic [DW_ADDR-1:0] b_q;
  logic [DW_ADDR-1:0] c_q;
  logic [DW_ADDR-1:0] base_sel;
  logic [DW_IDX-1:0]  row_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      row_q <= '0;
    end else if (latch) begin
      a_q   <= a_base;
      b_q   <= b_base;
      c_q   <= c_base;
      row_q <= '0;
    end else if (adv) begin
      row_q <= last ? '0 : row_q + 1'b1;
    end
  end

  always_comb begin
    base_sel = c_q;
    unique case (sel)
      OP_A:    base_sel = a_q;
      OP_B:    base_sel = b_q;
      default: base_sel = c_q;
    endcase
  end

  // Address wraps modulo 2^DW_ADDR by construction.
  assign addr = base_sel + DW_ADDR'(row_q);
  assign last = (row_q == DW_IDX'(M - 1));
  assign row  = row_q;

endmodule

// File: rtl/tc_tile_loader.sv
// Streams A, B, C tiles row by row into the core,
// kicks off compute and waits for M result rows.
module tc_tile_loader
  import tc_tile_loader_pkg::*;
#(
  parameter int M       = TC_M,
  parameter int DW_DATA = TC_DW_DATA,
  parameter int DW_IDX  = TC_DW_IDX,
  parameter int DW_MEM  = TC_DW_MEM,
  parameter int DW_ADDR = TC_DW_ADDR
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [DW_ADDR-1:0] a_base,
  input  logic [DW_ADDR-1:0] b_base,
  input  logic [DW_ADDR-1:0] c_base,
  output logic               busy,
  output logic               done,
  tc_tile_loader_if.master   mem,
  output logic               load_en,
  output logic               write_a,
  output logic               write_b,
  output logic               write_c,
  output logic [DW_MEM-1:0]  A_input,
  output logic [DW_MEM-1:0]  B_input,
  output logic [DW_MEM-1:0]  C_input,
  output logic [DW_IDX-1:0]  A_row,
  output logic [DW_IDX-1:0]  B_row,
  output logic [DW_IDX-1:0]  C_row,
  output logic               compute_en,
  input  logic               out_valid
);

  localparam int CW = $clog2(M + 1);

  tl_state_e          state;
  tl_op_e             sel;
  logic [CW-1:0]      res_cnt;
  logic [DW_IDX-1:0]  row;
  logic               last;
  logic               adv;
  logic               latch;
  logic [DW_MEM-1:0]  a_hold;
  logic [DW_MEM-1:0]  b_hold;
  logic [DW_MEM-1:0]  c_hold;
  logic               unused_geom;

  assign unused_geom = (DW_MEM % DW_DATA) == 0;

  assign mem.mem_rd_en = (state == LOAD_A) ||
                         (state == LOAD_B) ||
                         (state == LOAD_C);
  assign adv   = mem.mem_rd_en && mem.mem_gnt;
  assign latch = (state == IDLE) && start;

  always_comb begin
    sel = OP_A;
    unique case (1'b1)
      state == LOAD_B: sel = OP_B;
      state == LOAD_C: sel = OP_C;
      default:         sel = OP_A;
    endcase
  end

  tc_row_addr_gen #(
    .M       (M),
    .DW_IDX  (DW_IDX),
    .DW_ADDR (DW_ADDR)
  ) u_addr (
    .clk     (clk),
    .reset_n (reset_n),
    .latch   (latch),
    .a_base  (a_base),
    .b_base  (b_base),
    .c_base  (c_base),
    .sel     (sel),
    .adv     (adv),
    .row     (row),
    .addr    (mem.mem_rd_addr),
    .last    (last)
  );

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign compute_en = (state == COMPUTE);

  // Read data arrives the cycle after grant; hold it otherwise.
  assign A_input = write_a ? mem.mem_rd_data : a_hold;
  assign B_input = write_b ? mem.mem_rd_data : b_hold;
  assign C_input = write_c ? mem.mem_rd_data : c_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      res_cnt <= '0;
      load_en <= 1'b0;
      write_a <= 1'b0;
      write_b <= 1'b0;
      write_c <= 1'b0;
      A_row   <= '0;
      B_row   <= '0;
      C_row   <= '0;
      a_hold  <= '0;
      b_hold  <= '0;
      c_hold  <= '0;
    end else begin
      load_en <= adv;
      write_a <= adv && (state == LOAD_A);
      write_b <= adv && (state == LOAD_B);
      write_c <= adv && (state == LOAD_C);
      if (adv && state == LOAD_A) A_row <= row;
      if (adv && state == LOAD_B) B_row <= row;
      if (adv && state == LOAD_C) C_row <= row;
      if (write_a) a_hold <= mem.mem_rd_data;
      if (write_b) b_hold <= mem.mem_rd_data;
      if (write_c) c_hold <= mem.mem_rd_data;

      unique case (state)
        IDLE:     if (start) state <= LOAD_A;
        LOAD_A:   if (adv && last) state <= LOAD_B;
        LOAD_B:   if (adv && last) state <= LOAD_C;
        LOAD_C:   if (adv && last) state <= DRAIN;
        DRAIN:    state <= COMPUTE;
        COMPUTE: begin
          res_cnt <= '0;
          state   <= WAIT_OUT;
        end
        WAIT_OUT: begin
          if (out_valid) begin
            if (res_cnt == CW'(M - 1)) state <= DONE;
            else res_cnt <= res_cnt + 1'b1;
          end
        end
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
